// File: rtl/des_round_sequencer_if.sv
// Block-level valid/ready handshake between the DES core wrapper
// and the round sequencer.
interface des_round_sequencer_if;
  logic in_valid;
  logic in_ready;
  logic tdes_decrypt;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_valid,
    output tdes_decrypt,
    output out_ready,
    input  in_ready,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  tdes_decrypt,
    input  out_ready,
    output in_ready,
    output out_valid
  );
endinterface

// File: rtl/des_round_sequencer.sv
// Control FSM for the shared iterative DES/3DES-EDE round datapath.
// Optional abort input enabled by defining DES_SEQ_ABORT_EN.
module des_round_sequencer #(
  parameter int NUM_PASSES = 3,
  parameter int ROUNDS     = 16
) (
  input  logic       clk,
  input  logic       n_rst,
`ifdef DES_SEQ_ABORT_EN
  input  logic       abort,
`endif
  des_round_sequencer_if.slave blk,
  output logic       blk_load,
  output logic       load_sel,
  output logic       key_load,
  output logic [1:0] key_sel,
  output logic       pass_decrypt,
  output logic       round_en,
  output logic [1:0] key_shift_amt,
  output logic       key_shift_dir,
  output logic [3:0] round_idx,
  output logic [1:0] pass_idx,
  output logic       pass_end,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  localparam logic [3:0] RLAST = 4'(ROUNDS - 1);
  localparam logic [1:0] PLAST = 2'(NUM_PASSES - 1);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [1:0] pass_q, pass_d;
  logic       dec_q, dec_d;
  logic [1:0] sch_key;
  logic       sch_dec;

  function automatic logic [1:0] enc_amt(input logic [3:0] r);
    case (r)
      4'd0, 4'd1, 4'd8, 4'd15: enc_amt = 2'd1;
      default:                 enc_amt = 2'd2;
    endcase
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      round_q <= '0;
      pass_q  <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      pass_q  <= pass_d;
      dec_q   <= dec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    pass_d  = pass_q;
    dec_d   = dec_q;
    case (state_q)
      S_IDLE: begin
        if (blk.in_valid) begin
          dec_d   = blk.tdes_decrypt;
          pass_d  = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        round_d = '0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (round_q == RLAST) begin
          round_d = '0;
          state_d = S_FINAL;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      S_FINAL: begin
        if (pass_q == PLAST) begin
          state_d = S_DONE;
        end else begin
          pass_d  = pass_q + 2'd1;
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        if (blk.out_ready) begin
          round_d = '0;
          pass_d  = '0;
          dec_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef DES_SEQ_ABORT_EN
    if (abort && state_q != S_IDLE) begin
      round_d = '0;
      pass_d  = '0;
      dec_d   = 1'b0;
      state_d = S_IDLE;
    end
`endif
  end

  // EDE: encrypt runs K1,K2,K3 as E,D,E; decrypt runs K3,K2,K1 as D,E,D
  always_comb begin
    sch_key = '0;
    sch_dec = dec_q;
    if (NUM_PASSES != 1) begin
      sch_key = dec_q ? (2'd2 - pass_q) : pass_q;
      sch_dec = dec_q ^ pass_q[0];
    end
  end

  always_comb begin
    blk.in_ready  = 1'b0;
    blk.out_valid = 1'b0;
    blk_load      = 1'b0;
    key_load      = 1'b0;
    load_sel      = 1'b0;
    round_en      = 1'b0;
    pass_end      = 1'b0;
    key_shift_amt = 2'd0;
    key_shift_dir = 1'b0;
    busy          = (state_q != S_IDLE);
    key_sel       = busy ? sch_key : 2'd0;
    pass_decrypt  = busy ? sch_dec : 1'b0;
    round_idx     = round_q;
    pass_idx      = pass_q;
    unique case (state_q)
      S_IDLE: blk.in_ready = 1'b1;
      S_LOAD: begin
        blk_load = 1'b1;
        key_load = 1'b1;
        load_sel = (pass_q != 2'd0);
      end
      S_ROUND: begin
        round_en = 1'b1;
        // decrypt rotates right, mirroring the encrypt table from the end
        if (sch_dec) begin
          key_shift_dir = 1'b1;
          key_shift_amt = (round_q == 4'd0) ? 2'd0 : enc_amt(4'd0 - round_q);
        end else begin
          key_shift_amt = enc_amt(round_q);
        end
      end
      S_FINAL: pass_end = 1'b1;
      S_DONE:  blk.out_valid = 1'b1;
      default: ;
    endcase
  end

endmodule
